// File: rtl/sync_ram_dualport_clr.sv
// rtl/sync_ram_dualport_clr.sv - simple dual-port RAM with registered read and clear sweep (optional macro SYNC_RAM_PARITY_EN)
module sync_ram_dualport_clr #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              parity_err
);

`ifdef SYNC_RAM_PARITY_EN
    // Parity bit sits above the data bits in each stored word.
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    logic [MEM_W-1:0]  mem_q [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [MEM_W-1:0]  mem_wdata;

    logic              wr_in_range;
    logic              rd_in_range;
    logic              rd_fire;
    logic [MEM_W-1:0]  rd_word;

    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    // Addresses at or above DEPTH exist only when DEPTH is not a power of two.
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
    assign rd_fire     = (state_q == IDLE) && rd_en;
    assign rd_word     = rd_in_range ? mem_q[rd_addr] : '0;
    assign busy        = (state_q == CLEAR);

    // Next state and the single memory write port, shared by the sweep and user writes.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = '0;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                if (ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                if (wr_en && wr_in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_addr;
`ifdef SYNC_RAM_PARITY_EN
                    mem_wdata = {^wr_data, wr_data};
`else
                    mem_wdata = wr_data;
`endif
                end
                if (clr) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    // Sweep state and pointer; reset starts a fresh sweep from address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Storage array, deliberately without reset; the sweep does the clearing.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read port; sampling before the write lands gives read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= rd_word[DATA_W-1:0];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

`ifdef SYNC_RAM_PARITY_EN
    logic perr_q;

    // Parity check travels with the read data and is only meaningful with rd_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= rd_fire && rd_in_range && (^rd_word);
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_ram_dualport_clr.sv
// tb/tb_sync_ram_dualport_clr.sv - bench for sync_ram_dualport_clr at DEPTH 8 and DEPTH 6
module tb_sync_ram_dualport_clr;

    logic             clk;
    logic             rst_n;
    logic [1:0]       clr, wr_en, rd_en;
    logic [1:0][2:0]  wr_addr, rd_addr;
    logic [1:0][15:0] wr_data;
    logic [1:0]       busy, rd_valid, perr;
    logic [1:0][15:0] rd_data;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    sync_ram_dualport_clr #(.DATA_W(16), .DEPTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .clr(clr[0]), .busy(busy[0]),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
        .rd_valid(rd_valid[0]), .parity_err(perr[0])
    );

    sync_ram_dualport_clr #(.DATA_W(16), .DEPTH(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .clr(clr[1]), .busy(busy[1]),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
        .rd_valid(rd_valid[1]), .parity_err(perr[1])
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Behavioural model: memory contents, outstanding sweep length, expected read outputs.
    int          depth [2] = '{8, 6};
    logic [15:0] mmem  [2][8];
    bit          mbad  [2][8];
    int          sweep_left [2];
    logic [15:0] e_data [2];
    bit          e_valid [2];
    bit          e_perr [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                e_data[k] = 0; e_valid[k] = 0; e_perr[k] = 0;
                sweep_left[k] = depth[k];
            end else if (sweep_left[k] > 0) begin
                mmem[k][depth[k] - sweep_left[k]] = 0;
                mbad[k][depth[k] - sweep_left[k]] = 0;
                sweep_left[k]--;
                e_valid[k] = 0;
                e_perr[k]  = 0;
            end else begin
                e_valid[k] = rd_en[k];
                e_perr[k]  = 0;
                if (rd_en[k]) begin
                    if (int'(rd_addr[k]) < depth[k]) begin
                        e_data[k] = mmem[k][rd_addr[k]];
                        e_perr[k] = mbad[k][rd_addr[k]];
                    end else begin
                        e_data[k] = 0;
                    end
                end
                if (wr_en[k] && int'(wr_addr[k]) < depth[k]) begin
                    mmem[k][wr_addr[k]] = wr_data[k];
                    mbad[k][wr_addr[k]] = 0;
                end
                if (clr[k]) sweep_left[k] = depth[k];
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(sweep_left[k] > 0));
                chk($sformatf("rd_valid%0d", k), 32'(rd_valid[k]), 32'(e_valid[k]));
                chk($sformatf("rd_data%0d", k), 32'(rd_data[k]), 32'(e_data[k]));
                chk($sformatf("parity_err%0d", k), 32'(perr[k]), 32'(e_perr[k]));
            end
        end
    end

    task automatic do_write(int k, logic [2:0] a, logic [15:0] d);
        wr_en[k] = 1; wr_addr[k] = a; wr_data[k] = d;
        @(negedge clk);
        wr_en[k] = 0;
    endtask

    task automatic do_read(int k, logic [2:0] a, output logic [15:0] d, output logic v, output logic p);
        rd_en[k] = 1; rd_addr[k] = a;
        @(negedge clk);
        rd_en[k] = 0;
        d = rd_data[k]; v = rd_valid[k]; p = perr[k];
    endtask

    task automatic count_busy(output int c0, output int c1);
        c0 = 0; c1 = 0;
        for (int c = 0; c < 12; c++) begin
            c0 += int'(busy[0]);
            c1 += int'(busy[1]);
            @(negedge clk);
        end
    endtask

    logic [15:0] d;
    logic        v, p;
    int          c0, c1;

    initial begin
        rst_n = 0; clr = 0; wr_en = 0; rd_en = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_rd_valid", 32'(rd_valid[0]), 0);
        chk("reset_busy", 32'(busy[0]), 1);
        rst_n = 1;
        chk_en = 1;
        count_busy(c0, c1);
        chk("busy_len_reset_d8", c0, 8);
        chk("busy_len_reset_d6", c1, 6);

        for (int i = 0; i < 8; i++) begin
            do_read(0, 3'(i), d, v, p);
            chk("clr_read_data", 32'(d), 0);
            chk("clr_read_valid", 32'(v), 1);
        end

        for (int i = 0; i < 8; i++) do_write(0, 3'(i), 16'(32'h1111 * i));
        for (int i = 0; i < 8; i++) begin
            do_read(0, 3'(i), d, v, p);
            chk("sweep_read_data", 32'(d), 32'h1111 * i);
            chk("sweep_read_valid", 32'(v), 1);
        end

        // same-address write and read in one cycle
        wr_en[0] = 1; wr_addr[0] = 3; wr_data[0] = 16'hBEEF;
        rd_en[0] = 1; rd_addr[0] = 3;
        @(negedge clk);
        wr_en[0] = 0; rd_en[0] = 0;
        chk("collision_old", 32'(rd_data[0]), 32'h3333);
        do_read(0, 3, d, v, p);
        chk("collision_new", 32'(d), 32'hBEEF);

        // clear on request with traffic ignored while busy
        clr[0] = 1;
        @(negedge clk);
        clr[0] = 0;
        wr_en[0] = 1; wr_addr[0] = 1; wr_data[0] = 16'hFFFF;
        rd_en[0] = 1; rd_addr[0] = 2;
        c0 = 0;
        while (busy[0] && c0 < 20) begin
            c0++;
            chk("busy_rd_valid", 32'(rd_valid[0]), 0);
            @(negedge clk);
        end
        wr_en[0] = 0; rd_en[0] = 0;
        chk("busy_len_clr", c0, 8);
        for (int i = 0; i < 8; i++) begin
            do_read(0, 3'(i), d, v, p);
            chk("after_clr_data", 32'(d), 0);
        end

        // reset in the middle of a sweep
        do_write(0, 5, 16'h5555);
        do_read(0, 5, d, v, p);
        chk("pre_reset_data", 32'(d), 32'h5555);
        clr[0] = 1;
        @(negedge clk);
        clr[0] = 0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("midreset_busy", 32'(busy[0]), 1);
        chk("midreset_rd_valid", 32'(rd_valid[0]), 0);
        chk("midreset_rd_data", 32'(rd_data[0]), 0);
        @(negedge clk);
        rst_n = 1;
        count_busy(c0, c1);
        chk("busy_len_rerun_d8", c0, 8);
        chk("busy_len_rerun_d6", c1, 6);

        // non-power-of-two depth
        do_write(1, 7, 16'hAAAA);
        do_read(1, 7, d, v, p);
        chk("oor_read_data", 32'(d), 0);
        chk("oor_read_valid", 32'(v), 1);
        chk("oor_read_perr", 32'(p), 0);
        do_write(1, 2, 16'h1234);
        do_read(1, 2, d, v, p);
        chk("d6_read_data", 32'(d), 32'h1234);
        chk("d6_read_perr", 32'(p), 0);
`ifdef SYNC_RAM_PARITY_EN
        dut6.mem_q[2][0] = ~dut6.mem_q[2][0];
        mmem[1][2][0] = ~mmem[1][2][0];
        mbad[1][2] = 1;
        do_read(1, 2, d, v, p);
        chk("corrupt_perr", 32'(p), 1);
        chk("corrupt_data", 32'(d), 32'h1235);
`endif

        repeat (2) @(negedge clk);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_ram_dualport_clr.md
Name: sync_ram_dualport_clr

Overview:
- Parametrised successor to the 8x16 asynchronous single-port RAM.
- Synchronous simple dual-port memory: one write port and one read port, both on a single clock.
- Registered read with a valid strobe.
- Built-in clear engine zeroes every word after reset or on request; the memory array itself is never reset.

Parameters:
DATA_W, 16, data word width in bits (1..64)
DEPTH, 8, number of words (2..1024; need not be a power of two)
ADDR_W, $clog2(DEPTH), address width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clr  input  1  single-cycle pulse; starts a clear sweep (honoured only in IDLE)
busy  output  1  high while the clear sweep runs
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd_en  input  1  read strobe
rd_addr  input  ADDR_W  read address
rd_data  output  DATA_W  registered read data
rd_valid  output  1  high one cycle after an accepted read
parity_err  output  1  parity mismatch on current rd_data; tied 0 without PARITY_EN

Behaviour:
- Single clock domain: clk. Reset rst_n is asynchronous assert, active-low, synchronously released.
- Reset values:
  - rd_data = 0, rd_valid = 0, parity_err = 0.
  - busy = 1 and the FSM enters CLEAR with clear pointer = 0.
  - The array is not reset.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each cycle writes 0 to mem[ptr], then ptr increments.
  - When ptr = DEPTH-1 is written, the next state is IDLE and busy falls.
  - Total duration is exactly DEPTH cycles after reset release.
  - wr_en and rd_en are ignored (no write, rd_valid = 0, rd_data holds).
  - clr is ignored.
- IDLE:
  - clr = 1 → CLEAR with ptr = 0; busy rises the next cycle.
  - A clr cycle still services wr_en and rd_en presented in that same cycle.
- Write: wr_en = 1 in IDLE writes wr_data to mem[wr_addr] at the clock edge.
- Read:
  - rd_en = 1 in IDLE → on the next edge rd_data = mem[rd_addr] and rd_valid = 1. Latency is 1 cycle.
  - rd_en = 0 → rd_valid = 0 next cycle; rd_data holds its last value.
- Same-address read and write in one cycle: read-first. rd_data returns the old contents; the new value is visible to reads in later cycles.
- Out-of-range addresses (≥ DEPTH, possible when DEPTH is not a power of two):
  - Write is dropped.
  - Read returns rd_data = 0 with rd_valid = 1 and parity_err = 0.
- rst_n asserted mid-sweep or mid-read:
  - Outputs return to reset values immediately.
  - The sweep restarts from address 0 after release.
  - Array contents are left partially cleared until the new sweep finishes.
- Back-to-back reads every cycle yield rd_valid continuously high.

Optional Feature:
- Macro: SYNC_RAM_PARITY_EN.
- With the macro defined:
  - Each stored word carries one extra even-parity bit, computed as the XOR of wr_data on write.
  - The clear sweep writes parity 0.
  - On read, parity_err is registered alongside rd_data: 1 if the stored parity does not match the XOR of the stored data.
  - parity_err is valid only when rd_valid = 1; it is 0 otherwise.
  - Out-of-range reads give parity_err = 0.
  - A test hook force of one stored data bit must produce parity_err = 1.
- Without the macro:
  - No parity storage.
  - parity_err is tied to 0.

Test Plan:
- Reset clear (DATA_W=16, DEPTH=8): release rst_n → busy high for exactly 8 cycles, then 0. Reading addresses 0..7 → rd_data = 0x0000, rd_valid = 1 one cycle after each rd_en.
- Write/read sweep: write mem[i] = 16'h1111*i for i = 0..7. Then read 0..7 back-to-back → rd_data sequence 0x0000, 0x1111, ... 0x7777 with rd_valid continuously high.
- Read-first collision: mem[3] = 0x3333. In one cycle, write 0xBEEF to addr 3 and read addr 3 → rd_data = 0x3333. The next read of addr 3 → 0xBEEF.
- clr mid-use: after the write sweep, pulse clr → busy for 8 cycles. wr_en/rd_en during busy produce no writes and rd_valid = 0. Afterwards all addresses read 0.
- Reset mid-sweep: assert rst_n low at sweep cycle 4 → busy, rd_valid, and rd_data go to reset values immediately. After release, busy lasts a full 8 cycles.
- Non-power-of-two (DEPTH=6, ADDR_W=3): write 0xAAAA to addr 7 → dropped, and a read of addr 7 → 0x0000 with rd_valid = 1. With SYNC_RAM_PARITY_EN, corrupting one bit of mem[2] → parity_err = 1 on its read.
